// File: rtl/shift_register_8b_piso_tx.sv
// ---------------------------------------------------------------------------
// shift_register_8b_piso_tx
//
// Parallel-in / serial-out transmitter. A word is taken through a
// load_valid/load_ready handshake and shifted out one bit per enabled clock,
// framed by first/last markers. A new word can be accepted on the final bit
// of a frame, so consecutive frames run with no idle bit between them.
//
// Optional feature macro: PISO_PARITY_EN
//   defined   : an even-parity bit (^d captured at accept) follows the data
//               bits; the frame is WIDTH+1 bits and last marks the parity bit.
//   undefined : the frame is WIDTH bits; last marks the final data bit.
//
// Parameters
//   WIDTH      data word width (>= 2)
//   MSB_FIRST  1: d[WIDTH-1] goes out first, 0: d[0] goes out first
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   en          shift enable; low holds all shift state
//   d           parallel word to transmit
//   load_valid  source offers d
//   load_ready  transmitter can accept a word this cycle (combinational)
//   s_out       serial data (registered, 0 when idle)
//   s_valid     s_out carries a frame bit (registered)
//   first       s_out is the first frame bit (registered)
//   last        s_out is the final frame bit (registered)
//   busy        frame in flight, same as s_valid
// ---------------------------------------------------------------------------
module shift_register_8b_piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             first,
    output logic             last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);
`ifdef PISO_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(WIDTH);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt, cnt_inc;
    logic             s_out_nxt, s_valid_nxt, first_nxt, last_nxt;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             parity, parity_nxt;
`endif

    // Bit currently sitting at the output end of a word.
    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Move the word one place toward the output end, zero-filling behind.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // Ready in IDLE, or on the final bit of a frame when that bit will
    // actually retire this cycle (en high), which gives gapless frames.
    assign load_ready = !reset &&
                        ((state == IDLE) || ((bit_cnt == LAST_CNT) && en));
    assign accept     = load_valid && load_ready;
    assign cnt_inc    = bit_cnt + CNT_W'(1);
    assign busy       = s_valid;

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        s_out_nxt   = s_out;
        s_valid_nxt = s_valid;
        first_nxt   = first;
        last_nxt    = last;
`ifdef PISO_PARITY_EN
        parity_nxt  = parity;
`endif
        if (accept) begin
            state_nxt   = SHIFT;
            shreg_nxt   = d;
            bit_cnt_nxt = '0;
            s_out_nxt   = out_bit(d);
            s_valid_nxt = 1'b1;
            first_nxt   = 1'b1;
            last_nxt    = 1'b0;
`ifdef PISO_PARITY_EN
            parity_nxt  = ^d;
`endif
        end else if ((state == SHIFT) && en) begin
            if (bit_cnt == LAST_CNT) begin
                state_nxt   = IDLE;
                shreg_nxt   = '0;
                bit_cnt_nxt = '0;
                s_out_nxt   = 1'b0;
                s_valid_nxt = 1'b0;
                first_nxt   = 1'b0;
                last_nxt    = 1'b0;
            end else begin
                bit_cnt_nxt = cnt_inc;
                shreg_nxt   = shift_word(shreg);
                s_out_nxt   = out_bit(shift_word(shreg));
                first_nxt   = 1'b0;
                last_nxt    = (cnt_inc == LAST_CNT);
`ifdef PISO_PARITY_EN
                // All data bits have gone out; the trailing slot carries parity.
                if (cnt_inc == PAR_CNT) begin
                    s_out_nxt = parity;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            first   <= 1'b0;
            last    <= 1'b0;
`ifdef PISO_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            s_out   <= s_out_nxt;
            s_valid <= s_valid_nxt;
            first   <= first_nxt;
            last    <= last_nxt;
`ifdef PISO_PARITY_EN
            parity  <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_shift_register_8b_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_shift_register_8b_piso_tx
//
// Directed bench for shift_register_8b_piso_tx. Two instances share all
// inputs: one MSB-first, one LSB-first. Expected bit sequences are written
// in transmit order (leftmost literal bit goes out first).
// ---------------------------------------------------------------------------
module tb_shift_register_8b_piso_tx;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] d;
    logic       load_valid;

    logic lr_m, so_m, sv_m, fi_m, la_m, bu_m;
    logic lr_l, so_l, sv_l, fi_l, la_l, bu_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_register_8b_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .en(en), .d(d), .load_valid(load_valid),
        .load_ready(lr_m), .s_out(so_m), .s_valid(sv_m), .first(fi_m),
        .last(la_m), .busy(bu_m)
    );

    shift_register_8b_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .en(en), .d(d), .load_valid(load_valid),
        .load_ready(lr_l), .s_out(so_l), .s_valid(sv_l), .first(fi_l),
        .last(la_l), .busy(bu_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sv_m"}, {31'd0, sv_m}, 32'd0);
        chk({tag, "_so_m"}, {31'd0, so_m}, 32'd0);
        chk({tag, "_fi_m"}, {31'd0, fi_m}, 32'd0);
        chk({tag, "_la_m"}, {31'd0, la_m}, 32'd0);
        chk({tag, "_bu_m"}, {31'd0, bu_m}, 32'd0);
        chk({tag, "_sv_l"}, {31'd0, sv_l}, 32'd0);
        chk({tag, "_so_l"}, {31'd0, so_l}, 32'd0);
        chk({tag, "_bu_l"}, {31'd0, bu_l}, 32'd0);
    endtask

    // One full frame with en held high; called at #1 after a clock edge.
    task automatic send_frame(input string tag, input logic [7:0] w,
                              input logic [7:0] em, input logic [7:0] el,
                              input logic par);
        logic bm, bl;
        int   idx;
        d = w;
        load_valid = 1'b1;
        #1;
        chk({tag, "_rdy_idle"}, {31'd0, lr_m}, 32'd1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            idx = 7 - i;
            bm = (i < 8) ? em[idx] : par;
            bl = (i < 8) ? el[idx] : par;
            chk($sformatf("%s_so_m_b%0d", tag, i), {31'd0, so_m}, {31'd0, bm});
            chk($sformatf("%s_so_l_b%0d", tag, i), {31'd0, so_l}, {31'd0, bl});
            chk($sformatf("%s_sv_b%0d", tag, i), {30'd0, sv_m, sv_l}, 32'd3);
            chk($sformatf("%s_busy_b%0d", tag, i), {31'd0, bu_m}, 32'd1);
            chk($sformatf("%s_first_b%0d", tag, i), {31'd0, fi_m}, {31'd0, (i == 0)});
            chk($sformatf("%s_last_b%0d", tag, i), {30'd0, la_m, la_l},
                (i == FRAME - 1) ? 32'd3 : 32'd0);
            chk($sformatf("%s_rdy_b%0d", tag, i), {31'd0, lr_m}, {31'd0, (i == FRAME - 1)});
        end
        @(posedge clk); #1;
        chk_idle({tag, "_end"});
        chk({tag, "_rdy_end"}, {31'd0, lr_m}, 32'd1);
    endtask

    initial begin
        logic [10:0] stall_seq;
        logic        ebit;

        // Reset
        reset = 1'b1; en = 1'b1; d = 8'h00; load_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_idle("reset");
        chk("reset_rdy", {31'd0, lr_m}, 32'd0);
        reset = 1'b0;
        #1;
        chk("reset_rdy_rel", {31'd0, lr_m}, 32'd1);

        // Single frames
        send_frame("a5", 8'hA5, 8'b10100101, 8'b10100101, 1'b0);
        send_frame("01", 8'h01, 8'b00000001, 8'b10000000, 1'b1);

        // Back-to-back FF then 00 with load_valid held
        d = 8'hFF; load_valid = 1'b1;
        @(posedge clk); #1;
        d = 8'h00;
        for (int c = 1; c <= 2 * FRAME; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            ebit = (c <= 8);
            chk($sformatf("b2b_so_m_c%0d", c), {31'd0, so_m}, {31'd0, ebit});
            chk($sformatf("b2b_so_l_c%0d", c), {31'd0, so_l}, {31'd0, ebit});
            chk($sformatf("b2b_sv_c%0d", c), {31'd0, sv_m}, 32'd1);
            chk($sformatf("b2b_first_c%0d", c), {31'd0, fi_m},
                {31'd0, (c == 1 || c == FRAME + 1)});
            chk($sformatf("b2b_rdy_c%0d", c), {31'd0, lr_m},
                {31'd0, (c == FRAME || c == 2 * FRAME)});
            if (c == 2 * FRAME) load_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk_idle("b2b_end");

        // C3 with en low for 3 cycles after bit 2
        stall_seq = 11'b11111000011;
        d = 8'hC3; load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int c = 1; c <= FRAME + 3; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            ebit = (c <= 11) ? stall_seq[11 - c] : 1'b0;
            chk($sformatf("stall_so_m_c%0d", c), {31'd0, so_m}, {31'd0, ebit});
            chk($sformatf("stall_so_l_c%0d", c), {31'd0, so_l}, {31'd0, ebit});
            chk($sformatf("stall_sv_c%0d", c), {31'd0, sv_m}, 32'd1);
            chk($sformatf("stall_first_c%0d", c), {31'd0, fi_m}, {31'd0, (c == 1)});
            chk($sformatf("stall_last_c%0d", c), {31'd0, la_m}, {31'd0, (c == FRAME + 3)});
            if (c == 2) en = 1'b0;
            if (c == 5) en = 1'b1;
            #1;
            chk($sformatf("stall_rdy_c%0d", c), {31'd0, lr_m}, {31'd0, (c == FRAME + 3)});
        end
        @(posedge clk); #1;
        chk_idle("stall_end");

        // Reset in the middle of F0, with a word offered on the reset edge
        d = 8'hF0; load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            chk($sformatf("f0_so_m_c%0d", c), {31'd0, so_m}, 32'd1);
            chk($sformatf("f0_so_l_c%0d", c), {31'd0, so_l}, 32'd0);
        end
        reset = 1'b1; d = 8'h0F; load_valid = 1'b1;
        @(posedge clk); #1;
        chk_idle("midrst");
        chk("midrst_rdy", {31'd0, lr_m}, 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_rdy_rel", {31'd0, lr_m}, 32'd1);
        send_frame("0f", 8'h0F, 8'b00001111, 8'b11110000, 1'b0);

`ifdef PISO_PARITY_EN
        send_frame("par07", 8'h07, 8'b00000111, 8'b11100000, 1'b1);
        send_frame("par03", 8'h03, 8'b00000011, 8'b11000000, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
